// File: rtl/trap_sequencer.sv
`default_nettype none
// trap_sequencer: machine-mode trap / mret sequencer driving four implicit CSR slots
// and a valid/ready redirect to the pipeline.  Rev 1.0
module trap_sequencer #(
  parameter logic        VECTORED_EN = 1'b1,
  parameter logic [31:0] IRQ_MASK    = 32'h0000_0888
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         exc_valid,
  input  logic [4:0]   exc_cause,
  input  logic [31:0]  exc_tval,
  input  logic [31:0]  exc_pc,
  input  logic         mret_valid,
  input  logic         int_pc_valid,
  input  logic [31:0]  int_pc,
  input  logic         redirect_ready,
  input  logic [127:0] impl_csr,
  output logic [3:0]   impl_read_enable,
  output logic [47:0]  impl_addrs_r,
  output logic [3:0]   impl_write_enable,
  output logic [47:0]  impl_addrs_w,
  output logic [127:0] impl_write_data,
  output logic [1:0]   mode,
  output logic         busy,
  output logic         flush,
  output logic         redirect_valid,
  output logic [31:0]  redirect_pc
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TRAP_WR = 3'd1;
  localparam logic [2:0] S_RET_RD  = 3'd2;
  localparam logic [2:0] S_RET_WR  = 3'd3;
  localparam logic [2:0] S_REDIR   = 3'd4;

  localparam logic [1:0] MACHINE = 2'b11;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  logic [2:0]  state;
  logic [4:0]  cause_q;
  logic        is_irq_q;
  logic [31:0] tval_q;
  logic [31:0] epc_q;
  logic [31:0] mstatus_q;
  logic [1:0]  old_mode_q;
  logic [31:0] mtvec_q;

  logic [31:0] csr_mstatus;
  logic [31:0] csr_mie;
  logic [31:0] csr_mip;
  logic [31:0] csr_mtvec;
  logic [31:0] irq_vec;
  logic        irq_take;
  logic [4:0]  irq_cause;
  logic [31:0] trap_base;
  logic [31:0] trap_target;
  logic [31:0] trap_mstatus;
  logic [31:0] ret_mstatus;

  assign csr_mstatus = impl_csr[31:0];
  assign csr_mie     = impl_csr[63:32];
  assign csr_mip     = impl_csr[95:64];
  assign csr_mtvec   = impl_csr[127:96];

  assign irq_vec  = csr_mip & csr_mie & IRQ_MASK;
  assign irq_take = (|irq_vec) && (csr_mstatus[3] || (mode != MACHINE)) && int_pc_valid;

  // Lowest set bit as a fallback for non-standard mask bits; MEI > MSI > MTI override it.
  always_comb begin
    irq_cause = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (irq_vec[i]) irq_cause = 5'(i);
    end
    if (irq_vec[7])  irq_cause = 5'd7;
    if (irq_vec[3])  irq_cause = 5'd3;
    if (irq_vec[11]) irq_cause = 5'd11;
  end

  assign trap_base   = mtvec_q & ~32'h3;
  assign trap_target = (VECTORED_EN && (mtvec_q[1:0] == 2'b01) && is_irq_q)
                       ? trap_base + {25'd0, cause_q, 2'b00} : trap_base;

  always_comb begin
    trap_mstatus        = mstatus_q;
    trap_mstatus[7]     = mstatus_q[3];
    trap_mstatus[3]     = 1'b0;
    trap_mstatus[12:11] = old_mode_q;
  end

  always_comb begin
    ret_mstatus        = mstatus_q;
    ret_mstatus[3]     = mstatus_q[7];
    ret_mstatus[7]     = 1'b1;
    ret_mstatus[12:11] = 2'b00;
  end

  // All CSR-side outputs decode from registered state and latched data only.
  always_comb begin
    impl_read_enable  = 4'b0000;
    impl_write_enable = 4'b0000;
    case (state)
      S_IDLE:    impl_read_enable  = 4'b1111;
      S_RET_RD:  impl_read_enable  = 4'b0001;
      S_TRAP_WR: impl_write_enable = 4'b1111;
      S_RET_WR:  impl_write_enable = 4'b0001;
      default:   ;
    endcase
  end

  assign impl_addrs_r    = {CSR_MTVEC, CSR_MIP, CSR_MIE,
                            (state == S_RET_RD) ? CSR_MEPC : CSR_MSTATUS};
  assign impl_addrs_w    = {CSR_MTVAL, CSR_MCAUSE, CSR_MEPC, CSR_MSTATUS};
  assign impl_write_data = {tval_q, {is_irq_q, 26'd0, cause_q}, epc_q,
                            (state == S_RET_WR) ? ret_mstatus : trap_mstatus};

  assign busy           = (state != S_IDLE);
  assign redirect_valid = (state == S_REDIR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      mode        <= MACHINE;
      flush       <= 1'b0;
      redirect_pc <= 32'd0;
      cause_q     <= 5'd0;
      is_irq_q    <= 1'b0;
      tval_q      <= 32'd0;
      epc_q       <= 32'd0;
      mstatus_q   <= 32'd0;
      old_mode_q  <= 2'b00;
      mtvec_q     <= 32'd0;
    end else begin
      flush <= 1'b0;
      case (state)
        S_IDLE: begin
          if (exc_valid) begin
            cause_q    <= exc_cause;
            is_irq_q   <= 1'b0;
            tval_q     <= exc_tval;
            epc_q      <= exc_pc & ~32'h3;
            mstatus_q  <= csr_mstatus;
            old_mode_q <= mode;
            mtvec_q    <= csr_mtvec;
            flush      <= 1'b1;
            state      <= S_TRAP_WR;
          end else if (mret_valid) begin
            mstatus_q <= csr_mstatus;
            flush     <= 1'b1;
            state     <= S_RET_RD;
          end else if (irq_take) begin
            cause_q    <= irq_cause;
            is_irq_q   <= 1'b1;
            tval_q     <= 32'd0;
            epc_q      <= int_pc & ~32'h3;
            mstatus_q  <= csr_mstatus;
            old_mode_q <= mode;
            mtvec_q    <= csr_mtvec;
            flush      <= 1'b1;
            state      <= S_TRAP_WR;
          end
        end
        S_TRAP_WR: begin
          mode        <= MACHINE;
          redirect_pc <= trap_target;
          state       <= S_REDIR;
        end
        S_RET_RD: begin
          redirect_pc <= impl_csr[31:0];
          state       <= S_RET_WR;
        end
        S_RET_WR: begin
          mode  <= mstatus_q[12:11];
          state <= S_REDIR;
        end
        S_REDIR: begin
          if (redirect_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
